event_stream_buffer: RTL and testbench

Downstream consumer of the NEO processing unit. Watches the classifier's 32-bit event word and the raw spike flag, timestamps each new non-zero event against a free-running sample counter, and queues `{timestamp, event}` records in a FIFO. The FIFO drains over a valid/ready stream to the host-link packer. Also keeps a running spike total and a saturating drop counter for diagnostics.

---
 rtl/event_stream_buffer.sv | 127 ++++++++++++
 tb/tb_event_stream_buffer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_stream_buffer.sv
// event_stream_buffer
//   Timestamps each new non-zero classifier event against a free-running
//   sample counter and queues {timestamp, event} records in a first-word
//   fall-through FIFO. The FIFO drains over a valid/ready stream. A running
//   spike total and a saturating drop counter are kept for diagnostics.
//
// Parameters
//   DEPTH     FIFO entries (power of two, >= 2)
//   TS_WIDTH  timestamp counter width
//
// Ports
//   clk          sample clock, one input sample per cycle
//   rst          asynchronous active-low reset
//   spike_in     per-cycle spike flag
//   event_in     classifier event word, 0 = no event
//   m_tdata      head record {timestamp, event}, timestamp in the MSBs
//   m_tvalid     record available
//   m_tready     consumer accepts the head record
//   fifo_level   number of occupied entries
//   drop_count   events lost to a full FIFO, saturating at 0xFFFF
//   spike_total  spikes seen since reset, wraps modulo 2^32
module event_stream_buffer #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned TS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     spike_in,
  input  logic [31:0]              event_in,
  output logic [TS_WIDTH+31:0]     m_tdata,
  output logic                     m_tvalid,
  input  logic                     m_tready,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              drop_count,
  output logic [31:0]              spike_total
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;
  localparam int unsigned RW = TS_WIDTH + 32;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [TS_WIDTH-1:0] ts;
  logic [31:0]         event_prev;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [RW-1:0]       mem [DEPTH];

  logic push_req;
  logic pop;
  logic full;
  logic push_ok;
  logic drop;

  always_comb begin
    push_req = 1'b0;
    pop      = 1'b0;
    full     = 1'b0;
    push_ok  = 1'b0;
    drop     = 1'b0;
    // A held word is captured once; a change to another non-zero word
    // is a new event; returning to zero is not an event.
    push_req = (event_in != '0) && (event_in != event_prev);
    pop      = m_tvalid && m_tready;
    full     = (fifo_level == FULL_LEVEL);
    // When full, a same-cycle pop frees the slot the write lands in.
    push_ok  = push_req && (!full || pop);
    drop     = push_req && !push_ok;
  end

  // Valid and data derive only from registered state; the data is forced to
  // zero while empty so stale storage never shows on the bus.
  assign m_tvalid = (fifo_level != '0);
  assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ts         <= '0;
      event_prev <= '0;
    end else begin
      ts         <= ts + 1'b1;
      event_prev <= event_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push_ok, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= {ts, event_in};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count  <= '0;
      spike_total <= '0;
    end else begin
      if (drop && (drop_count != '1)) begin
        drop_count <= drop_count + 1'b1;
      end
      if (spike_in) begin
        spike_total <= spike_total + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_event_stream_buffer.sv
module tb_event_stream_buffer;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned TS_W  = 10;
  localparam int unsigned RW    = TS_W + 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            spike_in;
  logic [31:0]     event_in;
  logic [RW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            m_tready;
  logic [4:0]      fifo_level;
  logic [15:0]     drop_count;
  logic [31:0]     spike_total;

  event_stream_buffer #(
    .DEPTH(DEPTH),
    .TS_WIDTH(TS_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .spike_in(spike_in),
    .event_in(event_in),
    .m_tdata(m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .fifo_level(fifo_level),
    .drop_count(drop_count),
    .spike_total(spike_total)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model: queue of pending records plus plain counters.
  logic [RW-1:0] q[$];
  logic [TS_W-1:0] m_ts;
  logic [31:0]   m_prev;
  int unsigned   m_drop;
  logic [31:0]   m_spk;

  // Observations taken from the bus.
  logic [RW-1:0] seen[$];
  int unsigned   valid_cycles;
  logic          stall_prev;
  logic [RW-1:0] stall_data;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] rec(input int unsigned t, input logic [31:0] ev);
    return {TS_W'(t), ev};
  endfunction

  function automatic void model_clear();
    q.delete();
    m_ts       = '0;
    m_prev     = '0;
    m_drop     = 0;
    m_spk      = '0;
    stall_prev = 1'b0;
  endfunction

  // One sample cycle: compare at the falling edge, advance the model at the
  // rising edge with the inputs the DUT sampled there.
  task automatic step();
    logic pop;
    logic req;
    @(negedge clk);
    check("tvalid", 64'(m_tvalid), 64'(q.size() != 0));
    check("tdata", 64'(m_tdata), 64'((q.size() != 0) ? q[0] : '0));
    check("level", 64'(fifo_level), 64'(q.size()));
    check("drop", 64'(drop_count), 64'(m_drop));
    check("spikes", 64'(spike_total), 64'(m_spk));
    if (stall_prev) begin
      check("stall_valid", 64'(m_tvalid), 64'(1));
      check("stall_data", 64'(m_tdata), 64'(stall_data));
    end
    stall_prev = m_tvalid && !m_tready;
    stall_data = m_tdata;
    if (m_tvalid) valid_cycles++;
    if (m_tvalid && m_tready) seen.push_back(m_tdata);
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else begin
      pop = (q.size() != 0) && m_tready;
      req = (event_in != 0) && (event_in != m_prev);
      if (pop) void'(q.pop_front());
      if (req) begin
        if (q.size() < DEPTH) q.push_back(rec(m_ts, event_in));
        else if (m_drop < 65535) m_drop++;
      end
      m_prev = event_in;
      m_ts   = m_ts + 1'b1;
      if (spike_in) m_spk = m_spk + 1;
    end
    #1;
  endtask

  task automatic reset_dut();
    rst      = 1'b0;
    event_in = '0;
    spike_in = 1'b0;
    m_tready = 1'b0;
    model_clear();
    repeat (2) step();
    rst = 1'b1;
    seen.delete();
    valid_cycles = 0;
  endtask

  logic [31:0] sent[$];
  logic [31:0] tmp;

  initial begin
    rst = 1'b0;
    reset_dut();

    // 1: held event yields one record, visible one cycle later
    m_tready = 1'b1;
    repeat (5) step();
    event_in = 32'h3;
    repeat (10) step();
    event_in = '0;
    repeat (3) step();
    check("t1_count", 64'(seen.size()), 64'(1));
    check("t1_rec", 64'(seen[0]), 64'(rec(5, 32'h3)));
    check("t1_valid_cycles", 64'(valid_cycles), 64'(1));

    // 2: non-zero to non-zero change, return to zero
    reset_dut();
    m_tready = 1'b1;
    repeat (10) step();
    event_in = 32'h1; step();
    event_in = 32'h2; step();
    event_in = 32'h0; step();
    event_in = 32'h2; step();
    event_in = 32'h0;
    repeat (3) step();
    check("t2_count", 64'(seen.size()), 64'(3));
    check("t2_rec0", 64'(seen[0]), 64'(rec(10, 32'h1)));
    check("t2_rec1", 64'(seen[1]), 64'(rec(11, 32'h2)));
    check("t2_rec2", 64'(seen[2]), 64'(rec(13, 32'h2)));

    // 3: overflow
    reset_dut();
    m_tready = 1'b0;
    for (int unsigned i = 0; i < 20; i++) begin
      event_in = 32'(i + 1);
      step();
    end
    event_in = '0;
    step();
    check("t3_level", 64'(fifo_level), 64'(16));
    check("t3_drop", 64'(drop_count), 64'(4));

    // 4: push and pop in the same cycle while full
    m_tready = 1'b1;
    event_in = 32'h100;
    step();
    m_tready = 1'b0;
    event_in = '0;
    step();
    check("t4_level", 64'(fifo_level), 64'(16));
    check("t4_drop", 64'(drop_count), 64'(4));
    m_tready = 1'b1;
    repeat (20) step();
    check("t4_count", 64'(seen.size()), 64'(17));
    for (int unsigned i = 0; i < 16; i++) begin
      check("t3_order", 64'(seen[i][31:0]), 64'(i + 1));
    end
    check("t4_last", 64'(seen[16][31:0]), 64'(32'h100));

    // 5: random backpressure
    reset_dut();
    sent.delete();
    for (int unsigned i = 0; i < 200; i++) begin
      tmp = $urandom();
      event_in = {tmp[23:0], 8'(i + 1)};
      sent.push_back(event_in);
      for (int unsigned k = 0; k < 3; k++) begin
        spike_in = 1'($urandom_range(0, 1));
        m_tready = 1'($urandom_range(0, 1));
        step();
        event_in = '0;
      end
    end
    spike_in = 1'b0;
    m_tready = 1'b1;
    repeat (40) step();
    check("t5_count", 64'(seen.size()), 64'(200));
    check("t5_drop", 64'(drop_count), 64'(0));
    for (int unsigned i = 0; i < 200; i++) begin
      check("t5_order", 64'(seen[i][31:0]), 64'(sent[i]));
    end

    // 6: spikes, timestamp wrap, reset with records queued
    reset_dut();
    m_tready = 1'b0;
    for (int unsigned i = 0; i < 7; i++) begin
      spike_in = 1'b1; step();
      spike_in = 1'b0; step();
    end
    step();
    check("t6_spikes", 64'(spike_total), 64'(7));
    for (int k = 0; k < 2000 && m_ts != '1; k++) step();
    step();
    for (int unsigned i = 0; i < 5; i++) begin
      event_in = 32'hA0 + 32'(i);
      step();
    end
    event_in = '0;
    step();
    check("t6_level", 64'(fifo_level), 64'(5));
    check("t6_wrap_head", 64'(m_tdata), 64'(rec(0, 32'hA0)));
    #2 rst = 1'b0;
    #1;
    check("t6_rst_valid", 64'(m_tvalid), 64'(0));
    check("t6_rst_data", 64'(m_tdata), 64'(0));
    check("t6_rst_level", 64'(fifo_level), 64'(0));
    check("t6_rst_drop", 64'(drop_count), 64'(0));
    check("t6_rst_spikes", 64'(spike_total), 64'(0));
    model_clear();
    step();
    rst = 1'b1;
    repeat (5) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
